// File: rtl/simple_calculator_udiv_13ns_8ns_seq_if.sv
// Handshake and data bundle for the sequential unsigned divider.
// The master side issues requests and consumes results; the slave side is the divider.
interface simple_calculator_udiv_13ns_8ns_seq_if #(
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 8
);
    logic                  ap_start;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  ap_idle;
    logic                  ap_ready;
    logic                  ap_done;
    logic [din0_WIDTH-1:0] quot;
    logic [din1_WIDTH-1:0] rem;
    logic                  div_by_zero;

    modport master (
        output ap_start, din0, din1,
        input  ap_idle, ap_ready, ap_done, quot, rem, div_by_zero
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_idle, ap_ready, ap_done, quot, rem, div_by_zero
    );
endinterface

// File: rtl/simple_calculator_udiv_13ns_8ns_seq.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, MSB first.
// Fixed latency of din0_WIDTH+1 cycles from acceptance to ap_done, whatever the operands.
// Division by zero yields an all-ones quotient and the low dividend bits as remainder.
module simple_calculator_udiv_13ns_8ns_seq #(
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 8
) (
    input  logic ap_clk,
    input  logic ap_rst,
    simple_calculator_udiv_13ns_8ns_seq_if.slave bus
);

    localparam int CNT_W = $clog2(din0_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg;
    // Dividend bits shift out at the top while quotient bits shift in at the bottom,
    // so after din0_WIDTH steps this register holds the quotient.
    logic [din0_WIDTH-1:0] dividend_reg;
    logic [din1_WIDTH-1:0] divisor_reg;
    // Stored remainder stays below the divisor, so din1_WIDTH bits suffice; the
    // extra bit lives only in the shifted working value.
    logic [din1_WIDTH-1:0] part_rem_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [din0_WIDTH-1:0] quot_reg;
    logic [din1_WIDTH-1:0] rem_reg;
    logic                  dbz_reg;
    logic                  done_reg;

    logic                  start_accept;
    logic [din1_WIDTH:0]   shifted;
    logic                  q_bit;
    logic [din1_WIDTH-1:0] part_rem_next;
    logic [din0_WIDTH-1:0] dividend_next;

    // A start is taken only from IDLE and never while reset is being applied.
    assign start_accept = (state_reg == IDLE) && bus.ap_start && !ap_rst;

    assign bus.ap_ready    = start_accept;
    assign bus.ap_idle     = (state_reg == IDLE);
    assign bus.ap_done     = done_reg;
    assign bus.quot        = quot_reg;
    assign bus.rem         = rem_reg;
    assign bus.div_by_zero = dbz_reg;

    // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
    // The subtraction is only kept when shifted >= divisor, in which case the true
    // difference is below the divisor and the low din1_WIDTH bits are exact.
    always_comb begin
        shifted       = {part_rem_reg, dividend_reg[din0_WIDTH-1]};
        q_bit         = (shifted >= {1'b0, divisor_reg});
        part_rem_next = shifted[din1_WIDTH-1:0];
        if (q_bit) begin
            part_rem_next = shifted[din1_WIDTH-1:0] - divisor_reg;
        end
        dividend_next = {dividend_reg[din0_WIDTH-2:0], q_bit};
    end

    // Control FSM with datapath registers; results update only on entry to DONE.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg    <= IDLE;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            part_rem_reg <= '0;
            count_reg    <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            dbz_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.ap_start) begin
                        dividend_reg <= bus.din0;
                        divisor_reg  <= bus.din1;
                        part_rem_reg <= '0;
                        count_reg    <= CNT_W'(din0_WIDTH);
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    dividend_reg <= dividend_next;
                    part_rem_reg <= part_rem_next;
                    count_reg    <= count_reg - 1'b1;
                    // Last step: publish results so they are valid alongside ap_done.
                    if (count_reg == CNT_W'(1)) begin
                        quot_reg  <= dividend_next;
                        rem_reg   <= part_rem_next;
                        dbz_reg   <= (divisor_reg == '0);
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_calculator_udiv_13ns_8ns_seq.sv
// Self-checking bench for the sequential divider: directed cases, reset behaviour,
// and a back-to-back sweep of every divisor against an arithmetic reference model.
module tb_simple_calculator_udiv_13ns_8ns_seq;

    localparam int W0 = 13;
    localparam int W1 = 8;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    simple_calculator_udiv_13ns_8ns_seq_if #(.din0_WIDTH(W0), .din1_WIDTH(W1)) bus ();

    simple_calculator_udiv_13ns_8ns_seq #(.din0_WIDTH(W0), .din1_WIDTH(W1)) u_dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integer division, with the divide-by-zero convention.
    function automatic logic [W0-1:0] exp_quot(input int a, input int b);
        if (b == 0) return {W0{1'b1}};
        return W0'(a / b);
    endfunction

    function automatic logic [W1-1:0] exp_rem(input int a, input int b);
        if (b == 0) return W1'(a % 256);
        return W1'(a % b);
    endfunction

    // Issue one division from IDLE, check handshake, latency and results.
    task automatic run_op(input int a, input int b, input bit disturb);
        int k;
        bit seen;
        logic [W0-1:0] prev_q;
        for (int i = 0; i < 20 && !bus.ap_idle; i++) @(negedge ap_clk);
        bus.din0     = W0'(a);
        bus.din1     = W1'(b);
        bus.ap_start = 1'b1;
        #1;
        chk("ready_on_start", 32'(bus.ap_ready), 1);
        prev_q = bus.quot;
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        seen = 1'b0;
        k = 1;
        while (!seen && k <= 30) begin
            if (disturb && k == 3) begin
                bus.ap_start = 1'b1;
                bus.din0     = W0'(50);
                bus.din1     = W1'(5);
            end
            #1;
            if (disturb && k == 3) chk("ready_in_calc", 32'(bus.ap_ready), 0);
            if (bus.ap_done) begin
                seen = 1'b1;
            end else begin
                if (k == 5) chk("idle_in_calc", 32'(bus.ap_idle), 0);
                if (k == 7) chk("quot_hold_in_calc", 32'(bus.quot), 32'(prev_q));
                @(negedge ap_clk);
                k++;
            end
        end
        chk("latency", 32'(k), 14);
        chk("quot", 32'(bus.quot), 32'(exp_quot(a, b)));
        chk("rem", 32'(bus.rem), 32'(exp_rem(a, b)));
        chk("div_by_zero", 32'(bus.div_by_zero), (b == 0) ? 1 : 0);
        $display("[TB] op %0d / %0d -> quot=%0d rem=%0d dbz=%0d latency=%0d",
                 a, b, bus.quot, bus.rem, bus.div_by_zero, k);
        bus.ap_start = 1'b0;
        @(negedge ap_clk);
        #1;
        chk("done_one_cycle", 32'(bus.ap_done), 0);
        chk("idle_after_done", 32'(bus.ap_idle), 1);
    endtask

    initial begin
        int qa[$];
        int qb[$];
        int accepted;
        int cyc;
        int last_acc;
        int dones;
        int a;
        int b;

        // Reset with ap_start held high: the start must be ignored.
        bus.ap_start = 1'b1;
        bus.din0     = W0'(100);
        bus.din1     = W1'(7);
        repeat (3) @(negedge ap_clk);
        #1;
        chk("ready_during_reset", 32'(bus.ap_ready), 0);
        ap_rst       = 1'b0;
        bus.ap_start = 1'b0;
        #1;
        chk("rst_idle", 32'(bus.ap_idle), 1);
        chk("rst_done", 32'(bus.ap_done), 0);
        chk("rst_quot", 32'(bus.quot), 0);
        chk("rst_rem", 32'(bus.rem), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        @(negedge ap_clk);
        #1;
        chk("idle_after_reset", 32'(bus.ap_idle), 1);

        // Directed cases.
        run_op(100, 7, 1'b0);
        run_op(8191, 1, 1'b0);
        run_op(12, 255, 1'b0);
        run_op(5, 0, 1'b0);
        run_op(100, 7, 1'b1);

        // Reset five cycles into CALC discards the operation.
        @(negedge ap_clk);
        bus.din0     = W0'(100);
        bus.din1     = W1'(7);
        bus.ap_start = 1'b1;
        #1;
        chk("ready_before_abort", 32'(bus.ap_ready), 1);
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        repeat (4) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("abort_idle", 32'(bus.ap_idle), 1);
        chk("abort_quot", 32'(bus.quot), 0);
        chk("abort_rem", 32'(bus.rem), 0);
        chk("abort_dbz", 32'(bus.div_by_zero), 0);
        chk("abort_ready", 32'(bus.ap_ready), 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ap_done) dones++;
            @(negedge ap_clk);
            #1;
        end
        chk("abort_no_done", 32'(dones), 0);
        run_op(9, 4, 1'b0);

        // Back-to-back sweep over every divisor with ap_start held high.
        accepted = 0;
        cyc      = 0;
        last_acc = 0;
        @(negedge ap_clk);
        while ((accepted < 256 || qa.size() > 0) && cyc < 256 * 15 + 100) begin
            bus.ap_start = (accepted < 256);
            bus.din0     = W0'($urandom_range(0, 8191));
            bus.din1     = W1'(accepted);
            #1;
            if (bus.ap_done) begin
                if (qa.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    a = qa.pop_front();
                    b = qb.pop_front();
                    chk("sweep_quot", 32'(bus.quot), 32'(exp_quot(a, b)));
                    chk("sweep_rem", 32'(bus.rem), 32'(exp_rem(a, b)));
                    chk("sweep_dbz", 32'(bus.div_by_zero), (b == 0) ? 1 : 0);
                    $display("[TB] sweep %0d / %0d -> quot=%0d rem=%0d dbz=%0d",
                             a, b, bus.quot, bus.rem, bus.div_by_zero);
                end
            end
            if (bus.ap_ready) begin
                qa.push_back(int'(bus.din0));
                qb.push_back(int'(bus.din1));
                if (accepted > 0) chk("accept_interval", 32'(cyc - last_acc), 15);
                last_acc = cyc;
                accepted++;
            end
            @(negedge ap_clk);
            cyc++;
        end
        bus.ap_start = 1'b0;
        chk("sweep_accepted", 32'(accepted), 256);
        chk("sweep_drained", 32'(qa.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_calculator_udiv_13ns_8ns_seq.md
SIMPLE_CALCULATOR_UDIV_13NS_8NS_SEQ -- requirements
Module: simple_calculator_udiv_13ns_8ns_seq

Interface
REQ-001 Parameter din0_WIDTH, default 13, dividend width in bits.
REQ-002 Parameter din1_WIDTH, default 8, divisor width in bits.
REQ-003 ap_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 ap_rst  input  1  reset, synchronous, active-high.
REQ-005 ap_start  input  1  request a division; sampled only in IDLE.
REQ-006 din0  input  din0_WIDTH  unsigned dividend.
REQ-007 din1  input  din1_WIDTH  unsigned divisor.
REQ-008 ap_idle  output  1  high while in IDLE.
REQ-009 ap_ready  output  1  high in the cycle ap_start is accepted (operands captured).
REQ-010 ap_done  output  1  one-cycle pulse when results are valid.
REQ-011 quot  output  din0_WIDTH  unsigned quotient.
REQ-012 rem  output  din1_WIDTH  unsigned remainder.
REQ-013 div_by_zero  output  1  set when the completed operation had din1 == 0.

Function
REQ-014 States SHALL be IDLE, CALC, DONE; encoding left to implementer.
REQ-015 IDLE: ap_start=1 SHALL capture din0/din1 into internal registers, assert ap_ready combinationally that cycle, load iteration counter with din0_WIDTH, go to CALC.
REQ-016 IDLE with ap_start=0 SHALL remain in IDLE with outputs unchanged.
REQ-017 CALC SHALL run one restoring-division step per cycle, MSB first: partial remainder (din1_WIDTH+1 bits) shifted left with next dividend bit, divisor subtracted if result non-negative, quotient bit set accordingly.
REQ-018 CALC SHALL last exactly din0_WIDTH cycles, then go to DONE.
REQ-019 DONE SHALL update quot, rem, div_by_zero, assert ap_done for exactly one cycle, and return to IDLE next cycle.
REQ-020 Latency: start accepted in cycle N -> ap_done high in cycle N+din0_WIDTH+1 (N+14 at defaults), independent of operand values.
REQ-021 quot/rem/div_by_zero SHALL hold their values from DONE until the next DONE; they SHALL NOT change during CALC.
REQ-022 Results SHALL satisfy din0 == quot*din1 + rem, rem < din1, for din1 != 0.
REQ-023 din1 == 0: quot SHALL be all ones, rem SHALL be din0[din1_WIDTH-1:0], div_by_zero=1; same fixed latency.
REQ-024 ap_start while in CALC or DONE SHALL be ignored (no ap_ready, no operand capture); changes to din0/din1 after acceptance SHALL NOT affect the result.
REQ-025 ap_start held high continuously SHALL produce back-to-back operations, one acceptance per din0_WIDTH+2 cycles.
REQ-026 ap_idle SHALL be 0 in CALC and DONE, 1 in IDLE.

Reset
REQ-027 ap_rst=1 at a rising edge SHALL force IDLE regardless of current state, including mid-CALC; any in-flight operation SHALL be discarded with no ap_done.
REQ-028 Reset values: ap_idle=1, ap_ready=0, ap_done=0, quot=0, rem=0, div_by_zero=0, counter and internal registers 0.
REQ-029 ap_start sampled in the same cycle as ap_rst=1 SHALL be ignored.

Verification
REQ-030 din0=100, din1=7, start pulse -> ap_done 14 cycles later, quot=14, rem=2, div_by_zero=0.
REQ-031 din0=8191, din1=1 -> quot=8191, rem=0; then din0=12, din1=255 -> quot=0, rem=12.
REQ-032 din0=5, din1=0 -> quot=8191, rem=5, div_by_zero=1, ap_done at same latency.
REQ-033 Start 100/7, then ap_start=1 with din0=50, din1=5 during CALC -> no ap_ready, result still 14 r 2; din0/din1 changed mid-operation has no effect.
REQ-034 ap_rst asserted 5 cycles into CALC -> no ap_done, ap_idle=1 next cycle, all outputs 0; new 9/4 afterwards -> quot=2, rem=1.
REQ-035 Random sweep of all din1 values with random din0, ap_start held high -> every result satisfies REQ-022/REQ-023, acceptances every 15 cycles.
